// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the load/store stage in front of
// data_memory.
//   size_e    request width encoding (byte, half, word, reserved)
//   state_e   mem_access_unit sequencer states
//   AW_DEF    default data_memory word-address width
//   DW_DEF    data word width (sub-word lane logic assumes 4 bytes)
//   is_bad_req  misaligned / reserved-size detector
package mem_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_LOADWAIT,
    ST_DONE
  } state_e;

  // A request is rejected without touching memory when its byte address is
  // not naturally aligned for its size, or the size code is reserved.
  function automatic logic is_bad_req(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline-side request/response bundle of the load/store
// stage.
//   req, wr, size, sign_ext, addr, wdata : request (pipeline -> unit)
//   ready, done, err, rdata              : status/result (unit -> pipeline)
// Modports: master = pipeline, slave = mem_access_unit.
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic          sign_ext;
  logic [AW+1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, size, sign_ext, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, wr, size, sign_ext, addr, wdata,
    output ready, done, err, rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian lane handling for 32-bit words.
//   dm_q       word read from data_memory
//   wdata      sub-word store data (low 16 bits are all that can be merged)
//   addr_lo    byte offset within the word
//   size       request size (size_e encoding)
//   sign_ext   1 = sign-extend sub-word loads, 0 = zero-extend
//   load_val   extracted and extended load result
//   merge_val  dm_q with the addressed lane replaced by store data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] dm_q,
  input  logic [15:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_val,
  output logic [31:0] merge_val
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_shift = {addr_lo, 3'b000};
  assign half_shift = {addr_lo[1], 4'b0000};
  assign byte_sel   = dm_q[byte_shift +: 8];
  assign half_sel   = dm_q[half_shift +: 16];

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_val  = dm_q;
    merge_val = dm_q;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        merge_val[byte_shift +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
        merge_val[half_shift +: 16] = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage directly upstream of data_memory
// (2^AW x 32, synchronous read, word-only write).
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          request/response (mem_access_unit_if.slave)
//   dm_address   word address to data_memory
//   dm_data      write data to data_memory
//   dm_we        write enable to data_memory
//   dm_q         read data from data_memory, valid the cycle after an address
// Sub-word stores read the word in ACCESS and write the merged word in MERGE,
// because the memory has no byte enables.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
)(
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus,
  output logic [AW-1:0]       dm_address,
  output logic [DW-1:0]       dm_data,
  output logic                dm_we,
  input  logic [DW-1:0]       dm_q
);

  state_e        state;
  logic          wr_q;
  size_e         size_q;
  logic          sign_q;
  logic [AW+1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic [DW-1:0] load_val;
  logic [DW-1:0] merge_val;

  mem_lane_align u_lane_align (
    .dm_q      (dm_q),
    .wdata     (wdata_q[15:0]),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .sign_ext  (sign_q),
    .load_val  (load_val),
    .merge_val (merge_val)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            wr_q    <= bus.wr;
            size_q  <= size_e'(bus.size);
            sign_q  <= bus.sign_ext;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            err_q   <= is_bad_req(bus.size, bus.addr[1:0]);
            state   <= is_bad_req(bus.size, bus.addr[1:0]) ? ST_DONE : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!wr_q)                  state <= ST_LOADWAIT;
          else if (size_q == SZ_WORD) state <= ST_DONE;
          else                        state <= ST_MERGE;
        end
        ST_LOADWAIT: begin
          rdata_q <= load_val;
          state   <= ST_DONE;
        end
        ST_MERGE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded straight from state so an asynchronous reset drops
  // dm_we in the same instant, aborting any pending write.
  assign dm_we = ((state == ST_ACCESS) && wr_q && (size_q == SZ_WORD)) ||
                 (state == ST_MERGE);
  assign dm_address = addr_q[AW+1:2];
  assign dm_data    = (state == ST_MERGE) ? merge_val : wdata_q;

  assign bus.ready = (state == ST_IDLE);
  assign bus.done  = (state == ST_DONE);
  assign bus.err   = (state == ST_DONE) && err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a
// behavioural 1024 x 32 synchronous-read data_memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        preload;
  logic [9:0]  dm_address;
  logic [31:0] dm_data;
  logic        dm_we;
  logic [31:0] dm_q;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  // results of the last do_op call
  int          lat;
  int          we_cnt;
  logic        err_s;
  logic        rdy_a;
  logic [31:0] we_d;
  logic [9:0]  we_a;

  mem_access_unit_if #(.AW(10), .DW(32)) bus ();

  mem_access_unit #(.AW(10), .DW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dm_address (dm_address),
    .dm_data    (dm_data),
    .dm_we      (dm_we),
    .dm_q       (dm_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory model: Q registered from ADDRESS, word write on WE
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h8899AABB;
    end else if (dm_we) begin
      mem[dm_address] <= dm_data;
    end
    dm_q <= mem[dm_address];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request and observe it until DONE. lat counts clock edges from
  // E0 to the DONE cycle (0 = DONE right after E0).
  task automatic do_op(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [11:0] addr, input logic [31:0] wdata);
    int n;
    lat = -1; err_s = 1'b0; we_cnt = 0; we_d = '0; we_a = '0; rdy_a = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready=%b required 1", bus.ready);
      return;
    end
    bus.req = 1'b1; bus.wr = wr; bus.size = size; bus.sign_ext = sgn;
    bus.addr = addr; bus.wdata = wdata;
    @(negedge clk);
    // inputs are free to change once the request is taken
    bus.req = 1'b0; bus.wr = ~wr; bus.size = ~size; bus.sign_ext = ~sgn;
    bus.addr = ~addr; bus.wdata = ~wdata;
    for (int i = 0; i < 10; i++) begin
      if (dm_we) begin
        we_cnt++; we_d = dm_data; we_a = dm_address;
      end
      if (bus.done) begin
        lat = i; err_s = bus.err;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no DONE within 10 cycles");
    end else begin
      @(negedge clk);
      rdy_a = bus.ready && !bus.done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; preload = 1'b1;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    checks++;
    if ({bus.ready, bus.done, bus.err, dm_we} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: ready/done/err/we=%b required 1000",
               {bus.ready, bus.done, bus.err, dm_we});
    end
    checks++;
    if ({bus.rdata, dm_data, 22'(dm_address)} !== 86'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h dm_data=%h dm_address=%0d required 0",
               bus.rdata, dm_data, dm_address);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b required 1", bus.ready);
    end
  endtask

  task automatic test_load();
    do_op(1'b0, SZ_WORD, 1'b0, 12'h014, 32'h0);
    checks++;
    if (bus.rdata !== 32'h8899AABB || lat !== 2 || err_s !== 1'b0 || we_cnt !== 0) begin
      errors++;
      $display("FAIL load_word: rdata=%h lat=%0d err=%b we=%0d required 8899aabb 2 0 0",
               bus.rdata, lat, err_s, we_cnt);
    end
    checks++;
    if (rdy_a !== 1'b1) begin
      errors++; $display("FAIL done_one_cycle: ready_after=%b required 1", rdy_a);
    end
    do_op(1'b0, SZ_BYTE, 1'b1, 12'h015, 32'h0);
    checks++;
    if (bus.rdata !== 32'hFFFFFFAA || lat !== 2) begin
      errors++;
      $display("FAIL load_byte_signed: rdata=%h lat=%0d required ffffffaa 2", bus.rdata, lat);
    end
    do_op(1'b0, SZ_BYTE, 1'b0, 12'h015, 32'h0);
    checks++;
    if (bus.rdata !== 32'h000000AA) begin
      errors++; $display("FAIL load_byte_unsigned: rdata=%h required 000000aa", bus.rdata);
    end
    do_op(1'b0, SZ_HALF, 1'b1, 12'h016, 32'h0);
    checks++;
    if (bus.rdata !== 32'hFFFF8899) begin
      errors++; $display("FAIL load_half_signed: rdata=%h required ffff8899", bus.rdata);
    end
    do_op(1'b0, SZ_HALF, 1'b0, 12'h014, 32'h0);
    checks++;
    if (bus.rdata !== 32'h0000AABB) begin
      errors++; $display("FAIL load_half_unsigned: rdata=%h required 0000aabb", bus.rdata);
    end
    do_op(1'b0, SZ_BYTE, 1'b1, 12'h014, 32'h0);
    checks++;
    if (bus.rdata !== 32'hFFFFFFBB) begin
      errors++; $display("FAIL load_byte_lane0: rdata=%h required ffffffbb", bus.rdata);
    end
  endtask

  task automatic test_subword_store();
    do_op(1'b1, SZ_BYTE, 1'b0, 12'h016, 32'h00000011);
    checks++;
    if (we_cnt !== 1 || we_d !== 32'h8811AABB || we_a !== 10'd5 || lat !== 2 || err_s !== 1'b0) begin
      errors++;
      $display("FAIL store_byte_rmw: we=%0d data=%h addr=%0d lat=%0d err=%b required 1 8811aabb 5 2 0",
               we_cnt, we_d, we_a, lat, err_s);
    end
    checks++;
    if (bus.rdata !== 32'hFFFFFFBB) begin
      errors++; $display("FAIL store_keeps_rdata: rdata=%h required ffffffbb", bus.rdata);
    end
    do_op(1'b1, SZ_HALF, 1'b0, 12'h014, 32'hFFFF1234);
    checks++;
    if (mem[5] !== 32'h88111234 || we_cnt !== 1) begin
      errors++;
      $display("FAIL store_half_rmw: word5=%h we=%0d required 88111234 1", mem[5], we_cnt);
    end
    do_op(1'b0, SZ_WORD, 1'b0, 12'h014, 32'h0);
    checks++;
    if (bus.rdata !== 32'h88111234) begin
      errors++; $display("FAIL store_reload: rdata=%h required 88111234", bus.rdata);
    end
  endtask

  task automatic test_word_store();
    do_op(1'b1, SZ_WORD, 1'b0, 12'hFFC, 32'hDEADBEEF);
    checks++;
    if (we_cnt !== 1 || we_a !== 10'd1023 || we_d !== 32'hDEADBEEF || lat !== 1 || err_s !== 1'b0) begin
      errors++;
      $display("FAIL store_word: we=%0d addr=%0d data=%h lat=%0d err=%b required 1 1023 deadbeef 1 0",
               we_cnt, we_a, we_d, lat, err_s);
    end
    do_op(1'b0, SZ_WORD, 1'b1, 12'hFFC, 32'h0);
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_word_reload: rdata=%h required deadbeef", bus.rdata);
    end
  endtask

  task automatic test_errors();
    do_op(1'b0, SZ_HALF, 1'b1, 12'h013, 32'h0);
    checks++;
    if (err_s !== 1'b1 || lat !== 0 || we_cnt !== 0 || bus.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL err_half_misaligned: err=%b lat=%0d we=%0d rdata=%h required 1 0 0 deadbeef",
               err_s, lat, we_cnt, bus.rdata);
    end
    do_op(1'b1, SZ_WORD, 1'b0, 12'h016, 32'hCAFEF00D);
    checks++;
    if (err_s !== 1'b1 || lat !== 0 || we_cnt !== 0 || mem[5] !== 32'h88111234) begin
      errors++;
      $display("FAIL err_word_misaligned: err=%b lat=%0d we=%0d word5=%h required 1 0 0 88111234",
               err_s, lat, we_cnt, mem[5]);
    end
    do_op(1'b1, SZ_RSVD, 1'b0, 12'h014, 32'h55555555);
    checks++;
    if (err_s !== 1'b1 || lat !== 0 || we_cnt !== 0 || mem[5] !== 32'h88111234 ||
        bus.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL err_reserved_size: err=%b lat=%0d we=%0d word5=%h rdata=%h required 1 0 0 88111234 deadbeef",
               err_s, lat, we_cnt, mem[5], bus.rdata);
    end
  endtask

  task automatic test_reset_merge();
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = SZ_BYTE; bus.sign_ext = 1'b0;
    bus.addr = 12'h015; bus.wdata = 32'h00000077;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_we !== 1'b1) begin
      errors++; $display("FAIL merge_reached: dm_we=%b required 1", dm_we);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dm_we !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: dm_we=%b ready=%b required 0 1", dm_we, bus.ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (mem[5] !== 32'h88111234) begin
      errors++; $display("FAIL reset_abort_mem: word5=%h required 88111234", mem[5]);
    end
    do_op(1'b0, SZ_WORD, 1'b0, 12'h014, 32'h0);
    checks++;
    if (bus.rdata !== 32'h88111234) begin
      errors++; $display("FAIL reset_abort_reload: rdata=%h required 88111234", bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int n_ready;
    n_done = 0; n_ready = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = SZ_WORD; bus.sign_ext = 1'b0;
    bus.addr = 12'hFFC; bus.wdata = 32'h0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (bus.ready) n_ready++;
    end
    bus.req = 1'b0;
    checks++;
    if (n_done !== 3 || n_ready !== 2) begin
      errors++;
      $display("FAIL busy_req_ignored: done_pulses=%0d ready_cycles=%0d required 3 2",
               n_done, n_ready);
    end
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL back_to_back_rdata: rdata=%h required deadbeef", bus.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_subword_store();
    test_word_store();
    test_errors();
    test_reset_merge();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
